// File: rtl/prol16_mem_responder.sv
// PROL16 memory responder: word-addressed storage serving a CPU bus with
// active-low strobes, a backdoor preload port, serviced-access counters and
// a sticky protocol-error flag. A three-state FSM (LOAD, RUN, HALT) gates
// which port may touch the storage.
module prol16_mem_responder #(
    parameter int gDataWidth = 16,
    parameter int gAddrWidth = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [gDataWidth-1:0] mem_addr_i,
    input  logic [gDataWidth-1:0] mem_data_i,
    output logic [gDataWidth-1:0] mem_data_o,
    input  logic                  mem_ce_ni,
    input  logic                  mem_oe_ni,
    input  logic                  mem_we_ni,
    input  logic                  cpu_halt_i,
    input  logic                  load_en_i,
    input  logic [gAddrWidth-1:0] load_addr_i,
    input  logic [gDataWidth-1:0] load_data_i,
    input  logic                  load_done_i,
    output logic [15:0]           rd_count_o,
    output logic [15:0]           wr_count_o,
    output logic                  bus_err_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [gDataWidth-1:0]   data_q, data_d;
    logic [15:0]             rd_count_q, rd_count_d;
    logic [15:0]             wr_count_q, wr_count_d;
    logic                    bus_err_q, bus_err_d;

    // Storage is never cleared by reset; its contents survive a reset so the
    // CPU can be restarted against the previously loaded image.
    logic [gDataWidth-1:0]   storage [2**gAddrWidth];

    logic                    mem_we;
    logic [gAddrWidth-1:0]   mem_waddr;
    logic [gDataWidth-1:0]   mem_wdata;

    logic                    cpu_rd;
    logic                    cpu_wr;
    logic                    cpu_conflict;
    logic                    addr_ok;
    logic [gAddrWidth-1:0]   cpu_addr;

    // Decode the CPU strobes; ce_n high masks everything else.
    assign cpu_rd       = !mem_ce_ni && !mem_oe_ni &&  mem_we_ni;
    assign cpu_wr       = !mem_ce_ni &&  mem_oe_ni && !mem_we_ni;
    assign cpu_conflict = !mem_ce_ni && !mem_oe_ni && !mem_we_ni;
    assign cpu_addr     = mem_addr_i[gAddrWidth-1:0];
    // Addresses beyond the implemented range are rejected, not aliased.
    assign addr_ok      = (mem_addr_i[gDataWidth-1:gAddrWidth] == '0);

    // Next-state, access servicing and storage write-port selection.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        bus_err_d  = bus_err_q;
        mem_we     = 1'b0;
        mem_waddr  = load_addr_i;
        mem_wdata  = load_data_i;
        case (state_q)
            ST_LOAD: begin
                mem_we = load_en_i;
                if (load_done_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_rd) begin
                    if (addr_ok) begin
                        data_d = storage[cpu_addr];
                        if (rd_count_q != 16'hFFFF) begin
                            rd_count_d = rd_count_q + 16'd1;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end
                if (cpu_wr) begin
                    if (addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = cpu_addr;
                        mem_wdata = mem_data_i;
                        if (wr_count_q != 16'hFFFF) begin
                            wr_count_d = wr_count_q + 16'd1;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end
                if (cpu_conflict) begin
                    bus_err_d = 1'b1;
                end
                // The access on this edge still completes before halting.
                if (cpu_halt_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Control and output registers; storage writes are suppressed while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            data_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            bus_err_q  <= bus_err_d;
            if (mem_we) begin
                storage[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign mem_data_o = data_q;
    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
    assign bus_err_o  = bus_err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_prol16_mem_responder.sv
// Scoreboard bench for prol16_mem_responder: each directed step pushes the
// hand-computed post-edge outputs; a monitor pops and compares after each edge.
module tb_prol16_mem_responder;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_data_i = '0;
    logic [DW-1:0] mem_data_o;
    logic          mem_ce_ni = 1'b1;
    logic          mem_oe_ni = 1'b1;
    logic          mem_we_ni = 1'b1;
    logic          cpu_halt_i = 1'b0;
    logic          load_en_i = 1'b0;
    logic [AW-1:0] load_addr_i = '0;
    logic [DW-1:0] load_data_i = '0;
    logic          load_done_i = 1'b0;
    logic [15:0]   rd_count_o;
    logic [15:0]   wr_count_o;
    logic          bus_err_o;
    logic [1:0]    state_o;

    prol16_mem_responder #(.gDataWidth(DW), .gAddrWidth(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .mem_ce_ni   (mem_ce_ni),
        .mem_oe_ni   (mem_oe_ni),
        .mem_we_ni   (mem_we_ni),
        .cpu_halt_i  (cpu_halt_i),
        .load_en_i   (load_en_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i),
        .load_done_i (load_done_i),
        .rd_count_o  (rd_count_o),
        .wr_count_o  (wr_count_o),
        .bus_err_o   (bus_err_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [15:0] rd;
        logic [15:0] wr;
        logic        err;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: after each rising edge, check the expectation queued for it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (mem_data_o !== e.data || rd_count_o !== e.rd || wr_count_o !== e.wr ||
                bus_err_o !== e.err || state_o !== e.st) begin
                n_fail++;
                $display("FAIL %s: got data=%h rd=%0d wr=%0d err=%b st=%0d, want data=%h rd=%0d wr=%0d err=%b st=%0d",
                         e.name, mem_data_o, rd_count_o, wr_count_o, bus_err_o, state_o,
                         e.data, e.rd, e.wr, e.err, e.st);
            end
        end
    end

    task automatic expect_out(input string name, input logic [15:0] data, input logic [15:0] rd,
                              input logic [15:0] wr, input logic err, input logic [1:0] st);
        exp_t e;
        e.name = name; e.data = data; e.rd = rd; e.wr = wr; e.err = err; e.st = st;
        sb.push_back(e);
    endtask

    // Start a new step at the falling edge with every strobe inactive.
    task automatic step();
        @(negedge clk);
        mem_ce_ni = 1'b1; mem_oe_ni = 1'b1; mem_we_ni = 1'b1;
        mem_addr_i = '0; mem_data_i = '0;
        cpu_halt_i = 1'b0; load_en_i = 1'b0; load_done_i = 1'b0;
        load_addr_i = '0; load_data_i = '0;
    endtask

    task automatic cpu_rd(input logic [15:0] addr);
        mem_ce_ni = 1'b0; mem_oe_ni = 1'b0; mem_we_ni = 1'b1; mem_addr_i = addr;
    endtask

    task automatic cpu_wr(input logic [15:0] addr, input logic [15:0] data);
        mem_ce_ni = 1'b0; mem_oe_ni = 1'b1; mem_we_ni = 1'b0;
        mem_addr_i = addr; mem_data_i = data;
    endtask

    task automatic ld(input logic [AW-1:0] addr, input logic [15:0] data);
        load_en_i = 1'b1; load_addr_i = addr; load_data_i = data;
    endtask

    initial begin
        // Reset and preload
        step(); rst = 1'b1;                 expect_out("reset",            16'h0000, 0, 0, 0, 0);
        step(); rst = 1'b0; ld(5, 16'h1234); expect_out("preload5",        16'h0000, 0, 0, 0, 0);
        step(); ld(3, 16'h0001);            expect_out("preload3",         16'h0000, 0, 0, 0, 0);
        step(); ld(9, 16'h1111);            expect_out("preload9",         16'h0000, 0, 0, 0, 0);
        step(); ld(4, 16'h4444);            expect_out("preload4",         16'h0000, 0, 0, 0, 0);
        step(); rst = 1'b1; ld(4, 16'hDEAD); expect_out("rst_blocks_load", 16'h0000, 0, 0, 0, 0);
        step(); rst = 1'b0; cpu_rd(5);      expect_out("load_ignores_cpu", 16'h0000, 0, 0, 0, 0);
        step(); ld(2, 16'h0022); load_done_i = 1'b1;
                                            expect_out("load_and_done",    16'h0000, 0, 0, 0, 1);
        // RUN: basic reads and writes
        step(); cpu_rd(5);                  expect_out("read5",            16'h1234, 1, 0, 0, 1);
        step(); cpu_wr(7, 16'hBEEF);        expect_out("write7",           16'h1234, 1, 1, 0, 1);
        step(); cpu_rd(7);                  expect_out("raw7",             16'hBEEF, 2, 1, 0, 1);
        step(); ld(7, 16'h0000); cpu_rd(4); expect_out("run_ignores_load", 16'h4444, 3, 1, 0, 1);
        step(); cpu_rd(7);                  expect_out("read7_kept",       16'hBEEF, 4, 1, 0, 1);
        step(); cpu_rd(2);                  expect_out("read2",            16'h0022, 5, 1, 0, 1);
        step(); mem_ce_ni = 1'b1; mem_oe_ni = 1'b0; mem_we_ni = 1'b0; mem_addr_i = 16'd5;
                mem_data_i = 16'h7777;      expect_out("ce_high",          16'h0022, 5, 1, 0, 1);
        step(); mem_ce_ni = 1'b0;           expect_out("legal_idle",       16'h0022, 5, 1, 0, 1);
        // Out-of-range accesses
        step(); cpu_rd(16'h0400);           expect_out("oob_read",         16'h0022, 5, 1, 1, 1);
        step(); cpu_wr(16'h0405, 16'h9999); expect_out("oob_write",        16'h0022, 5, 1, 1, 1);
        step(); cpu_rd(5);                  expect_out("no_alias_write",   16'h1234, 6, 1, 1, 1);
        // Reset in the middle of a write
        step(); rst = 1'b1; cpu_wr(9, 16'h5555);
                                            expect_out("reset_mid_run",    16'h0000, 0, 0, 0, 0);
        step(); rst = 1'b0; load_done_i = 1'b1;
                                            expect_out("rerun",            16'h0000, 0, 0, 0, 1);
        step(); cpu_rd(9);                  expect_out("read9_intact",     16'h1111, 1, 0, 0, 1);
        // Strobe conflict
        step(); mem_ce_ni = 1'b0; mem_oe_ni = 1'b0; mem_we_ni = 1'b0; mem_addr_i = 16'd3;
                mem_data_i = 16'hFFFF;      expect_out("conflict",         16'h1111, 1, 0, 1, 1);
        step(); cpu_rd(3);                  expect_out("read3_unchanged",  16'h0001, 2, 0, 1, 1);
        // Halt with a coincident write
        step(); cpu_wr(2, 16'h00AA); cpu_halt_i = 1'b1;
                                            expect_out("halt_with_write",  16'h0001, 2, 1, 1, 2);
        step(); cpu_rd(2);                  expect_out("halt_ignores_rd",  16'h0001, 2, 1, 1, 2);
        step(); load_done_i = 1'b1; ld(2, 16'h0BAD);
                                            expect_out("halt_sticky",      16'h0001, 2, 1, 1, 2);
        step(); rst = 1'b1;                 expect_out("reset_from_halt",  16'h0000, 0, 0, 0, 0);
        step(); rst = 1'b0; load_done_i = 1'b1;
                                            expect_out("rerun2",           16'h0000, 0, 0, 0, 1);
        step(); cpu_rd(2);                  expect_out("read2_halt_write", 16'h00AA, 1, 0, 0, 1);
        // Read counter saturation
        for (int i = 0; i < 65533; i++) begin
            step(); cpu_rd(2);
        end
        step(); cpu_rd(2);                  expect_out("rd_at_max",        16'h00AA, 16'hFFFF, 0, 0, 1);
        step(); cpu_rd(2);                  expect_out("rd_saturated",     16'h00AA, 16'hFFFF, 0, 0, 1);
        step(); cpu_wr(6, 16'h0066);        expect_out("wr_after_sat",     16'h00AA, 16'hFFFF, 1, 0, 1);
        step();
        // Drain the scoreboard, bounded.
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prol16_mem_responder.md
PROL16_MEM_RESPONDER -- requirements
Module: prol16_mem_responder

Interface
REQ-001 SHALL have parameter gDataWidth, default 16, bus data and address width in bits.
REQ-002 SHALL have parameter gAddrWidth, default 10, implemented address bits; storage depth 2**gAddrWidth words.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 mem_addr_i  in  gDataWidth  word address driven by CPU.
REQ-007 mem_data_i  in  gDataWidth  write data driven by CPU.
REQ-008 mem_data_o  out  gDataWidth  read data returned to CPU.
REQ-009 mem_ce_ni / mem_oe_ni / mem_we_ni  in  1 each  active-low chip enable, output enable, write enable.
REQ-010 cpu_halt_i  in  1  CPU halt indication.
REQ-011 load_en_i  in  1  testbench backdoor write strobe.
REQ-012 load_addr_i  in  gAddrWidth  backdoor write address.
REQ-013 load_data_i  in  gDataWidth  backdoor write data.
REQ-014 load_done_i  in  1  end-of-preload pulse.
REQ-015 rd_count_o / wr_count_o  out  16 each  serviced CPU read / write counts.
REQ-016 bus_err_o  out  1  sticky protocol-error flag.
REQ-017 state_o  out  2  FSM state: 0 LOAD, 1 RUN, 2 HALT.

Function
REQ-018 FSM SHALL have states LOAD, RUN, HALT; LOAD->RUN on load_done_i high at an edge; RUN->HALT on cpu_halt_i high at an edge; HALT is left only by reset.
REQ-019 In LOAD, load_en_i high at an edge SHALL write load_data_i to storage[load_addr_i]; load_en_i SHALL be ignored in RUN and HALT.
REQ-020 load_en_i and load_done_i high on the same edge SHALL perform the write and enter RUN.
REQ-021 In LOAD and HALT all CPU strobes SHALL be ignored; mem_data_o, counters and bus_err_o hold.
REQ-022 In RUN, read = ce_n 0, oe_n 0, we_n 1 at an edge: mem_data_o SHALL take storage[mem_addr_i[gAddrWidth-1:0]] at that edge (latency 1 cycle); rd_count_o increments.
REQ-023 In RUN, write = ce_n 0, we_n 0, oe_n 1 at an edge: storage SHALL take mem_data_i at that edge; wr_count_o increments; mem_data_o holds.
REQ-024 Read in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 ce_n high SHALL mean no access, regardless of oe_n/we_n; mem_data_o holds.
REQ-026 ce_n 0 with oe_n 0 and we_n 0 SHALL perform neither access and set bus_err_o.
REQ-027 An access whose mem_addr_i bits above gAddrWidth-1 are non-zero SHALL be ignored (no write, mem_data_o holds, no count) and set bus_err_o.
REQ-028 ce_n 0 with oe_n 1 and we_n 1 SHALL be a legal idle; no access, no error.
REQ-029 Counters SHALL saturate at 0xFFFF, never wrap.
REQ-030 bus_err_o SHALL stay high until reset once set.
REQ-031 A legal access and cpu_halt_i high on the same edge in RUN SHALL complete the access, then enter HALT.

Reset
REQ-032 rst high SHALL immediately force state LOAD, mem_data_o 0, rd_count_o 0, wr_count_o 0, bus_err_o 0.
REQ-033 Storage contents SHALL NOT be cleared by reset; a write coinciding with rst high SHALL NOT be performed.
REQ-034 Reset asserted mid-RUN SHALL return to LOAD; a subsequent load_done_i re-enters RUN with prior contents intact.

Verification
REQ-035 Preload addr 5 = 0x1234, load_done_i, CPU read addr 5 -> mem_data_o 0x1234 one cycle later, rd_count_o 1, state_o 1.
REQ-036 CPU write 0xBEEF to addr 7, read addr 7 next cycle -> mem_data_o 0xBEEF, wr_count_o 1, rd_count_o 1.
REQ-037 ce_n 0, oe_n 0, we_n 0 at addr 3 holding 0x0001 with mem_data_i 0xFFFF -> bus_err_o 1, addr 3 still 0x0001, counters unchanged.
REQ-038 Read at mem_addr_i 0x0400 (gAddrWidth 10) -> bus_err_o 1, mem_data_o unchanged, rd_count_o unchanged.
REQ-039 cpu_halt_i with write 0x00AA to addr 2 on same edge -> state_o 2, addr 2 = 0x00AA; later read strobes ignored, rd_count_o unchanged.
REQ-040 Assert rst mid-RUN during a write of 0x5555 to addr 9 (prior 0x1111) -> outputs zero, state_o 0; after load_done_i, read addr 9 -> 0x1111.
